// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back requester, decode and register-file port bundle
interface rf_wb_arbiter_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    // ALU write-back request
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    // Load write-back request
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    // Multiply/divide write-back request
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    // Decode-side scoreboard control
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic              flush;

    // Register file write port and scoreboard status
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                RegWrite;
    logic [NUM_REGS-1:0] busy;
    logic                sb_err;

    // Pipeline side: requesters and decode drive, register file listens
    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        output rsv_valid, rsv_addr, flush,
        input  wr_addr, wr_data, RegWrite, busy, sb_err
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        input  rsv_valid, rsv_addr, flush,
        output wr_addr, wr_data, RegWrite, busy, sb_err
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin register-file write-port arbiter with busy scoreboard
module rf_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus
);

    // Round-robin pointer: the requester that gets first look this cycle
    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_MEM = 2'd1,
        PTR_MDU = 2'd2
    } ptr_t;

    ptr_t                ptr_q;
    logic [2:0]          req;
    logic [2:0]          gnt;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_nonzero;

    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                reg_write_q;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                sb_err_q;
    logic                set_en;
    logic                clr_en;
    logic                err_hit;

    // While reset is held nothing may be granted, so pending requests are dropped
    assign req = rst ? {bus.mdu_valid, bus.mem_valid, bus.alu_valid} : 3'b000;

    // One-hot grant: first valid requester scanning from the pointer, wrapping mod 3
    always_comb begin
        gnt = 3'b000;
        case (ptr_q)
            PTR_MEM: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            PTR_MDU: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    assign bus.alu_ready = gnt[0];
    assign bus.mem_ready = gnt[1];
    assign bus.mdu_ready = gnt[2];
    assign xfer          = |gnt;

    // Route the granted requester's address and data toward the write registers
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (gnt)
            3'b001: begin
                sel_addr = bus.alu_addr;
                sel_data = bus.alu_data;
            end
            3'b010: begin
                sel_addr = bus.mem_addr;
                sel_data = bus.mem_data;
            end
            3'b100: begin
                sel_addr = bus.mdu_addr;
                sel_data = bus.mdu_data;
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
    end

    // Register 0 is hardwired, so writes to it are accepted but never committed
    assign sel_nonzero = (sel_addr != '0);

    // Pointer rotation and the registered register-file write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= PTR_ALU;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            reg_write_q <= 1'b0;
        end else begin
            reg_write_q <= xfer && sel_nonzero;
            if (xfer) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
                case (gnt)
                    3'b001:  ptr_q <= PTR_MEM;
                    3'b010:  ptr_q <= PTR_MDU;
                    default: ptr_q <= PTR_ALU;
                endcase
            end
        end
    end

    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.RegWrite = reg_write_q;

    // Scoreboard events for this edge
    assign set_en = bus.rsv_valid && (bus.rsv_addr != '0);
    assign clr_en = xfer && sel_nonzero;

    // A reservation collides only if the register stays busy through this edge;
    // a same-edge write-back or a flush frees it first
    assign err_hit = set_en && busy_q[bus.rsv_addr]
                     && !(clr_en && (sel_addr == bus.rsv_addr))
                     && !bus.flush;

    // Next scoreboard: clear, then set (newer reservation wins), then flush overrides
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[bus.rsv_addr] = 1'b1;
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state and sticky collision flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            if (err_hit) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.sb_err = sb_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) ifc ();

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rv [3];
    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic        rsv_v;
    logic [4:0]  rsv_a;
    logic        fl;

    int          m_ptr;
    int          last_w;
    logic [31:0] m_busy;
    logic        m_err;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ifc.alu_valid = rv[0]; ifc.alu_addr = ra[0]; ifc.alu_data = rd[0];
        ifc.mem_valid = rv[1]; ifc.mem_addr = ra[1]; ifc.mem_data = rd[1];
        ifc.mdu_valid = rv[2]; ifc.mdu_addr = ra[2]; ifc.mdu_data = rd[2];
        ifc.rsv_valid = rsv_v; ifc.rsv_addr = rsv_a; ifc.flush = fl;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0;
        end
        rsv_v = 1'b0;
        rsv_a = 5'd0;
        fl    = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        last_w  = -1;
        m_busy  = 32'h0;
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'h0;
    endtask

    function automatic int winner();
        for (int k = 0; k < 3; k++) begin
            if (rv[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_update();
        int         w;
        logic       clr;
        logic [4:0] ca;
        w   = winner();
        clr = 1'b0;
        ca  = 5'd0;
        if (w >= 0) begin
            m_we    = (ra[w] != 5'd0);
            m_waddr = ra[w];
            m_wdata = rd[w];
            m_ptr   = (w + 1) % 3;
            clr     = (ra[w] != 5'd0);
            ca      = ra[w];
        end else begin
            m_we = 1'b0;
        end
        if (rsv_v && rsv_a != 5'd0 && m_busy[rsv_a] && !(clr && ca == rsv_a) && !fl)
            m_err = 1'b1;
        if (clr) m_busy[ca] = 1'b0;
        if (rsv_v && rsv_a != 5'd0) m_busy[rsv_a] = 1'b1;
        if (fl) m_busy = 32'h0;
        last_w = w;
    endtask

    task automatic step();
        int w;
        drive();
        @(negedge clk);
        w = winner();
        chk("alu_ready", ifc.alu_ready, (w == 0));
        chk("mem_ready", ifc.mem_ready, (w == 1));
        chk("mdu_ready", ifc.mdu_ready, (w == 2));
        chk("RegWrite", ifc.RegWrite, m_we);
        chk("wr_addr", ifc.wr_addr, m_waddr);
        chk("wr_data", ifc.wr_data, m_wdata);
        chk("busy", ifc.busy, m_busy);
        chk("sb_err", ifc.sb_err, m_err);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_all();
        for (int i = 0; i < 3; i++) begin
            ra[i] = 5'd0;
            rd[i] = 32'h0;
        end
        drive();
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_RegWrite", ifc.RegWrite, 1'b0);
        chk("reset_wr_addr", ifc.wr_addr, 5'd0);
        chk("reset_wr_data", ifc.wr_data, 32'h0);
        chk("reset_busy", ifc.busy, 32'h0);
        chk("reset_sb_err", ifc.sb_err, 1'b0);
        chk("reset_no_ready", ifc.alu_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        rv[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'hDEADBEEF;
        step();
        rv[0] = 1'b0;
        chk("t1_RegWrite", ifc.RegWrite, 1'b1);
        chk("t1_wr_addr", ifc.wr_addr, 5'd5);
        chk("t1_wr_data", ifc.wr_data, 32'hDEADBEEF);
        step();
        chk("t1_RegWrite_drop", ifc.RegWrite, 1'b0);
        step();

        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1;
            ra[i] = 5'(i + 1);
            rd[i] = 32'h1000 + 32'(i);
        end
        for (int c = 0; c < 7; c++) begin
            step();
            chk("t2_RegWrite", ifc.RegWrite, 1'b1);
            chk("t2_rotation", ifc.wr_addr, 5'(((last_w + 3) % 3) + 1));
        end
        idle_all();
        step();

        rsv_v = 1'b1; rsv_a = 5'd7;
        step();
        rsv_v = 1'b0;
        chk("t3_busy7_set", ifc.busy[7], 1'b1);
        step(); step(); step();
        rv[1] = 1'b1; ra[1] = 5'd7; rd[1] = 32'h77;
        step();
        rv[1] = 1'b0;
        chk("t3_busy7_clear", ifc.busy[7], 1'b0);
        chk("t3_sb_err", ifc.sb_err, 1'b0);

        rsv_v = 1'b1; rsv_a = 5'd9;
        step();
        rv[0] = 1'b1; ra[0] = 5'd9; rd[0] = 32'h99;
        step();
        rv[0] = 1'b0; rsv_v = 1'b0;
        chk("t4_busy9_kept", ifc.busy[9], 1'b1);
        chk("t4_no_err", ifc.sb_err, 1'b0);
        rsv_v = 1'b1; rsv_a = 5'd4;
        step();
        step();
        rsv_v = 1'b0;
        chk("t4_err_set", ifc.sb_err, 1'b1);
        step(); step();
        chk("t4_err_sticky", ifc.sb_err, 1'b1);

        fl = 1'b1;
        step();
        fl = 1'b0;
        rv[2] = 1'b1; ra[2] = 5'd0; rd[2] = 32'h55AA;
        rsv_v = 1'b1; rsv_a = 5'd0;
        step();
        idle_all();
        chk("t5_no_write", ifc.RegWrite, 1'b0);
        chk("t5_busy_zero", ifc.busy, 32'h0);
        step();

        for (int r = 4; r < 16; r++) begin
            if ((r % 8) >= 4) begin
                rsv_v = 1'b1; rsv_a = 5'(r);
                step();
            end
        end
        rsv_v = 1'b0;
        chk("t6_busy_f0f0", ifc.busy, 32'h0000F0F0);
        fl = 1'b1; rsv_v = 1'b1; rsv_a = 5'd2;
        step();
        idle_all();
        chk("t6_flush", ifc.busy, 32'h0);

        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1;
            ra[i] = 5'(20 + i);
            rd[i] = 32'hA0 + 32'(i);
        end
        rsv_v = 1'b1; rsv_a = 5'd30;
        step();
        rsv_v = 1'b0;
        step();
        chk("t6_pre_reset_we", ifc.RegWrite, 1'b1);
        rst = 1'b0;
        idle_all();
        drive();
        #2;
        chk("t6_async_we", ifc.RegWrite, 1'b0);
        chk("t6_async_busy", ifc.busy, 32'h0);
        chk("t6_async_err", ifc.sb_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1;
            ra[i] = 5'(10 + i);
            rd[i] = 32'hB0 + 32'(i);
        end
        step();
        chk("t6_first_grant", ifc.wr_addr, 5'd10);
        idle_all();
        step();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_w == i || !rv[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra[i] = 5'($urandom_range(0, 31));
                    rd[i] = $urandom;
                end else if ($urandom_range(0, 9) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            rsv_v = ($urandom_range(0, 9) < 3);
            rsv_a = 5'($urandom_range(0, 31));
            fl    = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
